// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// ID/EX sequencing for the pipelined RAT MCU: a scoreboard of in-flight
// register-file writes detects RAW hazards, a taken branch in EX flushes
// IF/ID, and a small FSM runs interrupt entry (drain, interrupt pulse,
// vector load).
// Build option: define HAZ_FWD_EN to enable EX/WB forwarding selects so that
// only late (load) results and older producers stall the front end.
module pipeline_hazard_ctrl #(
    parameter int         PIPE_DEPTH = 2,
    parameter logic [9:0] VEC_ADDR   = 10'h3FF,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_uses_x,
    input  logic             id_uses_y,
    input  logic [4:0]       id_addr_x,
    input  logic [4:0]       id_addr_y,
    input  logic             id_rf_wr,
    input  logic [4:0]       id_wb_addr,
    input  logic             ex_is_load,
    input  logic             ex_br_taken,
    input  logic             int_req,
    input  logic             int_en,
    output logic             pc_stall,
    output logic             ifid_flush,
    output logic             idex_nop,
    output logic             idex_int,
    output logic             pc_vec_ld,
    output logic [9:0]       vec_addr,
    output logic             int_ack,
    output logic [1:0]       fwd_x,
    output logic [1:0]       fwd_y,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_INTR  = 2'd2;
    localparam logic [1:0] ST_VEC   = 2'd3;

    // Match vectors are padded to at least 3 bits so the EX / WB / older
    // split below is well formed for any PIPE_DEPTH; padding bits are 0.
    localparam int MW = (PIPE_DEPTH < 2) ? 3 : PIPE_DEPTH + 1;

    logic [PIPE_DEPTH-1:0] r_sb_vld;
    logic [4:0]            r_sb_addr [PIPE_DEPTH];
    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic [MW-1:0]         w_match_x;
    logic [MW-1:0]         w_match_y;
    logic                  w_src_x;
    logic                  w_src_y;
    logic                  w_haz_x;
    logic                  w_haz_y;
    logic                  w_hazard;
    logic [1:0]            w_fwd_x;
    logic [1:0]            w_fwd_y;
    logic [PIPE_DEPTH-1:0] w_vld_shift;
    logic                  w_drain_done;
    logic                  w_issue;

    logic                  w_pc_stall;
    logic                  w_flush;
    logic                  w_nop;
    logic                  w_int;
    logic                  w_vec_ld;
    logic                  w_ack;

    assign w_src_x = id_valid & id_uses_x;
    assign w_src_y = id_valid & id_uses_y;

    // Per-entry address compare against both ID sources; entry 0 is the
    // instruction now in EX, entry 1 the one in WB, and so on.
    genvar gi;
    generate
        for (gi = 0; gi < MW; gi++) begin : g_match
            if (gi < PIPE_DEPTH) begin : g_live
                assign w_match_x[gi] = r_sb_vld[gi] && (r_sb_addr[gi] == id_addr_x);
                assign w_match_y[gi] = r_sb_vld[gi] && (r_sb_addr[gi] == id_addr_y);
            end else begin : g_pad
                assign w_match_x[gi] = 1'b0;
                assign w_match_y[gi] = 1'b0;
            end
        end
    endgenerate

`ifdef HAZ_FWD_EN
    // Youngest matching producer wins: EX result forwards unless it is a
    // late SCR/IN result (entry 0's load bit is ex_is_load itself, as that
    // entry describes the EX instruction), WB result forwards, older stalls.
    function automatic logic [2:0] resolve_src(input logic src,
                                               input logic [MW-1:0] m,
                                               input logic ld);
        logic [2:0] res;
        res = 3'b000;
        if (src) begin
            if (m[0]) begin
                res = ld ? 3'b100 : 3'b001;
            end else if (m[1]) begin
                res = 3'b010;
            end else if (|m[MW-1:2]) begin
                res = 3'b100;
            end
        end
        return res;
    endfunction

    assign {w_haz_x, w_fwd_x} = resolve_src(w_src_x, w_match_x, ex_is_load);
    assign {w_haz_y, w_fwd_y} = resolve_src(w_src_y, w_match_y, ex_is_load);
`else
    // Without forwarding every in-flight producer of a used source stalls.
    logic w_unused_load;
    assign w_unused_load = ex_is_load;
    assign w_haz_x = w_src_x & (|w_match_x);
    assign w_haz_y = w_src_y & (|w_match_y);
    assign w_fwd_x = 2'd0;
    assign w_fwd_y = 2'd0;
`endif

    assign w_hazard = w_haz_x | w_haz_y;

    // The oldest entry retires this cycle, so the pipe is empty after this
    // edge when every younger entry is invalid (DRAIN only inserts bubbles).
    assign w_vld_shift  = r_sb_vld << 1;
    assign w_drain_done = (w_vld_shift == '0);

    // Control outputs and next state; a taken branch overrides every hold.
    always_comb begin
        w_pc_stall   = 1'b0;
        w_flush      = 1'b0;
        w_nop        = 1'b0;
        w_int        = 1'b0;
        w_vec_ld     = 1'b0;
        w_ack        = 1'b0;
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_hazard) begin
                    w_pc_stall = 1'b1;
                    w_nop      = 1'b1;
                end else if (int_req && int_en && !ex_br_taken) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_pc_stall = 1'b1;
                w_nop      = 1'b1;
                if (w_drain_done) begin
                    w_state_next = ST_INTR;
                end
            end
            ST_INTR: begin
                w_int        = 1'b1;
                w_pc_stall   = 1'b1;
                w_ack        = 1'b1;
                w_state_next = ST_VEC;
            end
            ST_VEC: begin
                w_vec_ld     = 1'b1;
                w_flush      = 1'b1;
                w_nop        = 1'b1;
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
        if (ex_br_taken) begin
            w_pc_stall = 1'b0;
            w_flush    = 1'b1;
            w_nop      = 1'b1;
        end
    end

    // Reset forces every control output low in the same cycle it is asserted.
    assign pc_stall   = w_pc_stall & ~rst;
    assign ifid_flush = w_flush & ~rst;
    assign idex_nop   = w_nop & ~rst;
    assign idex_int   = w_int & ~rst;
    assign pc_vec_ld  = w_vec_ld & ~rst;
    assign int_ack    = w_ack & ~rst;
    assign fwd_x      = rst ? 2'd0 : w_fwd_x;
    assign fwd_y      = rst ? 2'd0 : w_fwd_y;
    assign vec_addr   = VEC_ADDR;
    assign stall_cnt  = rst ? '0 : r_stall_cnt;

    assign w_issue = id_valid & ~idex_nop;

    // Scoreboard shift: a real issue enters as valid, bubbles enter invalid.
    generate
        for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_sb
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sb_vld[gi]  <= 1'b0;
                    r_sb_addr[gi] <= 5'd0;
                end else if (gi == 0) begin
                    r_sb_vld[gi]  <= w_issue & id_rf_wr;
                    r_sb_addr[gi] <= id_wb_addr;
                end else begin
                    r_sb_vld[gi]  <= r_sb_vld[(gi > 0) ? gi - 1 : 0];
                    r_sb_addr[gi] <= r_sb_addr[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    // Interrupt-entry state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Saturating count of front-end stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (pc_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hazard stalls (and forwarding
// when HAZ_FWD_EN is defined), branch override, interrupt entry, masking,
// reset mid-sequence and stall counter saturation. A second instance with a
// deep scoreboard reaches counter saturation in a short run.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_x, id_uses_y, id_rf_wr;
    logic [4:0]  id_addr_x, id_addr_y, id_wb_addr;
    logic        ex_is_load, ex_br_taken, int_req, int_en;

    logic        pc_stall, ifid_flush, idex_nop, idex_int, pc_vec_ld, int_ack;
    logic [9:0]  vec_addr;
    logic [1:0]  fwd_x, fwd_y;
    logic [15:0] stall_cnt;

    logic        c_pc_stall, c_ifid_flush, c_idex_nop, c_idex_int, c_pc_vec_ld, c_int_ack;
    logic [9:0]  c_vec_addr;
    logic [1:0]  c_fwd_x, c_fwd_y;
    logic [15:0] c_stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.PIPE_DEPTH(2), .VEC_ADDR(10'h3FF), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_uses_x(id_uses_x),
        .id_uses_y(id_uses_y), .id_addr_x(id_addr_x), .id_addr_y(id_addr_y),
        .id_rf_wr(id_rf_wr), .id_wb_addr(id_wb_addr), .ex_is_load(ex_is_load),
        .ex_br_taken(ex_br_taken), .int_req(int_req), .int_en(int_en),
        .pc_stall(pc_stall), .ifid_flush(ifid_flush), .idex_nop(idex_nop),
        .idex_int(idex_int), .pc_vec_ld(pc_vec_ld), .vec_addr(vec_addr),
        .int_ack(int_ack), .fwd_x(fwd_x), .fwd_y(fwd_y), .stall_cnt(stall_cnt)
    );

    pipeline_hazard_ctrl #(.PIPE_DEPTH(64), .VEC_ADDR(10'h3FF), .CNT_W(16)) u_cnt (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_uses_x(id_uses_x),
        .id_uses_y(id_uses_y), .id_addr_x(id_addr_x), .id_addr_y(id_addr_y),
        .id_rf_wr(id_rf_wr), .id_wb_addr(id_wb_addr), .ex_is_load(ex_is_load),
        .ex_br_taken(ex_br_taken), .int_req(int_req), .int_en(int_en),
        .pc_stall(c_pc_stall), .ifid_flush(c_ifid_flush), .idex_nop(c_idex_nop),
        .idex_int(c_idex_int), .pc_vec_ld(c_pc_vec_ld), .vec_addr(c_vec_addr),
        .int_ack(c_int_ack), .fwd_x(c_fwd_x), .fwd_y(c_fwd_y), .stall_cnt(c_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_valid = 1'b0; id_uses_x = 1'b0; id_uses_y = 1'b0; id_rf_wr = 1'b0;
        id_addr_x = 5'd0; id_addr_y = 5'd0; id_wb_addr = 5'd0;
        ex_is_load = 1'b0; ex_br_taken = 1'b0; int_req = 1'b0; int_en = 1'b0;
    endtask

    initial begin
        // Reset with active inputs: outputs must still be low.
        clr();
        rst = 1'b1; ex_br_taken = 1'b1; int_req = 1'b1; int_en = 1'b1;
        step(); step(); #1;
        check("rst_flush", 32'(ifid_flush), 0);
        check("rst_stall", 32'(pc_stall), 0);
        check("rst_nop",   32'(idex_nop), 0);
        check("rst_ack",   32'(int_ack), 0);
        check("rst_vec",   32'(vec_addr), 32'h3FF);
        check("rst_cnt",   32'(stall_cnt), 0);
        clr(); rst = 1'b0;
        step();

        // Write r1, then read r1 in the next instruction.
        id_valid = 1'b1; id_rf_wr = 1'b1; id_wb_addr = 5'd1; #1;
        check("wr1_stall", 32'(pc_stall), 0);
        step();
        id_rf_wr = 1'b0; id_uses_x = 1'b1; id_addr_x = 5'd1; #1;
`ifndef HAZ_FWD_EN
        check("hz1_stall", 32'(pc_stall), 1);
        check("hz1_nop",   32'(idex_nop), 1);
        check("hz1_fwd",   32'(fwd_x), 0);
        step(); #1;
        check("hz2_stall", 32'(pc_stall), 1);
        check("hz2_nop",   32'(idex_nop), 1);
        step(); #1;
        check("hz3_stall", 32'(pc_stall), 0);
        check("hz3_nop",   32'(idex_nop), 0);
        check("hz3_cnt",   32'(stall_cnt), 2);
`else
        check("fw1_stall", 32'(pc_stall), 0);
        check("fw1_fwd",   32'(fwd_x), 1);
        step();
        id_uses_x = 1'b0; id_rf_wr = 1'b1; id_wb_addr = 5'd1; #1;
        check("fw2_stall", 32'(pc_stall), 0);
        step();
        id_rf_wr = 1'b0; id_uses_x = 1'b1; id_addr_x = 5'd1; ex_is_load = 1'b1; #1;
        check("ld1_stall", 32'(pc_stall), 1);
        check("ld1_fwd",   32'(fwd_x), 0);
        step();
        ex_is_load = 1'b0; #1;
        check("ld2_stall", 32'(pc_stall), 0);
        check("ld2_fwd",   32'(fwd_x), 2);
        check("ld2_cnt",   32'(stall_cnt), 1);
`endif
        clr(); step(); step(); step();

        // Branch taken while the Y source is stalled on a late result.
        id_valid = 1'b1; id_rf_wr = 1'b1; id_wb_addr = 5'd3; #1;
        check("br0_stall", 32'(pc_stall), 0);
        step();
        id_rf_wr = 1'b0; id_uses_y = 1'b1; id_addr_y = 5'd3;
        ex_is_load = 1'b1; ex_br_taken = 1'b1; #1;
        check("br_stall", 32'(pc_stall), 0);
        check("br_flush", 32'(ifid_flush), 1);
        check("br_nop",   32'(idex_nop), 1);
        step();
        ex_br_taken = 1'b0; ex_is_load = 1'b0; #1;
        check("brn_flush", 32'(ifid_flush), 0);
`ifndef HAZ_FWD_EN
        check("brn_stall", 32'(pc_stall), 1);
`else
        check("brn_stall", 32'(pc_stall), 0);
        check("brn_fwd",   32'(fwd_y), 2);
`endif
        clr(); step(); step(); step();

        // Interrupt entry with a writer just issued; request drops in DRAIN.
        id_valid = 1'b1; id_rf_wr = 1'b1; id_wb_addr = 5'd7; int_req = 1'b1; int_en = 1'b1; #1;
        check("ir_run_stall", 32'(pc_stall), 0);
        check("ir_run_nop",   32'(idex_nop), 0);
        step();
        id_valid = 1'b0; id_rf_wr = 1'b0; int_req = 1'b0; #1;
        check("d1_stall", 32'(pc_stall), 1);
        check("d1_nop",   32'(idex_nop), 1);
        check("d1_ack",   32'(int_ack), 0);
        step(); #1;
        check("d2_stall", 32'(pc_stall), 1);
        check("d2_int",   32'(idex_int), 0);
        check("d2_ack",   32'(int_ack), 0);
        step(); #1;
        check("in_int",   32'(idex_int), 1);
        check("in_ack",   32'(int_ack), 1);
        check("in_stall", 32'(pc_stall), 1);
        step(); #1;
        check("vec_ld",    32'(pc_vec_ld), 1);
        check("vec_flush", 32'(ifid_flush), 1);
        check("vec_nop",   32'(idex_nop), 1);
        check("vec_addr",  32'(vec_addr), 32'h3FF);
        check("vec_ack",   32'(int_ack), 0);
        check("vec_stall", 32'(pc_stall), 0);
        step(); #1;
        check("post_ld",  32'(pc_vec_ld), 0);
        check("post_int", 32'(idex_int), 0);

        // Masked request: nothing happens.
        int_en = 1'b0; int_req = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mask_stall", 32'(pc_stall), 0);
            check("mask_ack",   32'(int_ack), 0);
            step();
        end

        // Reset while draining: back to RUN and no acknowledge.
        clr(); int_en = 1'b1; int_req = 1'b1; id_valid = 1'b1; id_rf_wr = 1'b1; id_wb_addr = 5'd9;
        step();
        clr(); #1;
        check("rd_stall", 32'(pc_stall), 1);
        step();
        rst = 1'b1; #1;
        check("rr_stall", 32'(pc_stall), 0);
        check("rr_ack",   32'(int_ack), 0);
        check("rr_cnt",   32'(stall_cnt), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rq_ack",   32'(int_ack), 0);
            check("rq_stall", 32'(pc_stall), 0);
            step();
        end

        // Repeated interrupt entry with a writer issued each time:
        // depth 64 gives 65 stall cycles per 67, depth 2 gives 3 per 5.
        rst = 1'b1;
        step();
        rst = 1'b0; id_valid = 1'b1; id_rf_wr = 1'b1; id_wb_addr = 5'd5;
        int_req = 1'b1; int_en = 1'b1;
        repeat (67000) @(posedge clk);
        #1;
        check("cnt_deep_65000", 32'(c_stall_cnt), 65000);
        check("cnt_main_40200", 32'(stall_cnt), 40200);
        repeat (2000) @(posedge clk);
        #1;
        check("cnt_sat", 32'(c_stall_cnt), 32'hFFFF);
        check("cnt_main_41400", 32'(stall_cnt), 41400);
        repeat (300) @(posedge clk);
        #1;
        check("cnt_hold", 32'(c_stall_cnt), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
